keypad_scanner_4x4: RTL and testbench

Input-side companion to the multiplexed 7-segment output. The block scans a 4x4 passive key matrix by driving one column low at a time and sampling the four row lines. It debounces the full 16-key snapshot and reports single-key press events through a 32-bit status word. The SoC I/O decoder reads this word directly and software clears events with an acknowledge pulse.

---
 rtl/keypad_scanner_4x4.sv | 195 +++++++++++++++++++
 tb/tb_keypad_scanner_4x4.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_4x4.sv
// 4x4 key matrix scanner: walks one active-low column at a time, debounces the
// full 16-key snapshot and reports single-key press events in a status word.
module keypad_scanner_4x4 #(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        CLK,
  input  logic        RES_N,
  output logic [3:0]  COL,
  input  logic [3:0]  ROW,
  input  logic        ACK,
  output logic [31:0] KEY_REG,
  output logic        IRQ
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int MW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [MW-1:0] MATCH_SAT = MW'(DEBOUNCE_SCANS - 1);

  localparam logic [1:0] ST_COL0 = 2'd0;
  localparam logic [1:0] ST_COL1 = 2'd1;
  localparam logic [1:0] ST_COL2 = 2'd2;
  localparam logic [1:0] ST_COL3 = 2'd3;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Lowest set bit wins; only ever called on a one-hot snapshot.
  function automatic logic [3:0] first_set16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  logic [3:0]    row_meta_r;
  logic [3:0]    row_sync_r;
  logic [TW-1:0] tick_r;
  logic [1:0]    col_idx_r;
  logic [1:0]    col_idx_next_s;
  logic [3:0]    col_r;
  logic [3:0]    col_drive_s;
  logic [15:0]   snap_r;
  logic [15:0]   snap_next_s;
  logic [15:0]   prev_r;
  logic [15:0]   deb_r;
  logic [MW-1:0] match_r;
  logic [MW-1:0] match_next_s;
  logic          tick_end_s;
  logic          scan_end_s;
  logic          deb_load_s;
  logic          press_s;
  logic [3:0]    code_r;
  logic          multi_r;
  logic          held_r;
  logic          ovr_r;
  logic          valid_r;

  assign tick_end_s = (tick_r == TICK_LAST);
  assign scan_end_s = tick_end_s && (col_idx_r == ST_COL3);

  // Two-flop synchronizer, stored inverted so 1 means "key closed".
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      row_meta_r <= 4'b0000;
      row_sync_r <= 4'b0000;
    end else begin
      row_meta_r <= ~ROW;
      row_sync_r <= row_meta_r;
    end
  end

  // Next column index and the matching one-hot-low column pattern.
  always_comb begin
    col_idx_next_s = col_idx_r;
    if (tick_end_s) begin
      col_idx_next_s = col_idx_r + 2'd1;
    end else begin
      col_idx_next_s = col_idx_r;
    end
    case (col_idx_next_s)
      ST_COL0: col_drive_s = 4'b1110;
      ST_COL1: col_drive_s = 4'b1101;
      ST_COL2: col_drive_s = 4'b1011;
      ST_COL3: col_drive_s = 4'b0111;
      default: col_drive_s = 4'b1110;
    endcase
  end

  // Dwell counter, column index and registered column drive.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      tick_r    <= {TW{1'b0}};
      col_idx_r <= ST_COL0;
      col_r     <= 4'b1110;
    end else begin
      if (tick_end_s) begin
        tick_r <= {TW{1'b0}};
      end else begin
        tick_r <= tick_r + TW'(1);
      end
      col_idx_r <= col_idx_next_s;
      col_r     <= col_drive_s;
    end
  end

  // Merge the current column's rows into the snapshot at the end of its dwell.
  always_comb begin
    snap_next_s = snap_r;
    if (tick_end_s) begin
      for (int r = 0; r < 4; r++) begin
        snap_next_s[{2'(r), col_idx_r}] = row_sync_r[r];
      end
    end else begin
      snap_next_s = snap_r;
    end
  end

  // Match counter: saturates while consecutive full snapshots agree.
  always_comb begin
    match_next_s = match_r;
    if (!scan_end_s) begin
      match_next_s = match_r;
    end else if (snap_next_s != prev_r) begin
      match_next_s = {MW{1'b0}};
    end else if (match_r == MATCH_SAT) begin
      match_next_s = match_r;
    end else begin
      match_next_s = match_r + MW'(1);
    end
  end

  assign deb_load_s = scan_end_s && (match_next_s == MATCH_SAT);
  assign press_s    = deb_load_s && (popcount16(deb_r) == 5'd0) &&
                      (popcount16(snap_next_s) == 5'd1);

  // Snapshot, previous snapshot, match count and debounced state.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      snap_r  <= 16'h0000;
      prev_r  <= 16'h0000;
      deb_r   <= 16'h0000;
      match_r <= {MW{1'b0}};
    end else begin
      snap_r <= snap_next_s;
      if (scan_end_s) begin
        prev_r  <= snap_next_s;
        match_r <= match_next_s;
      end
      if (deb_load_s) begin
        deb_r <= snap_next_s;
      end
    end
  end

  // Status bits; a press event takes priority over a coincident ACK.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      code_r  <= 4'd0;
      multi_r <= 1'b0;
      held_r  <= 1'b0;
      ovr_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      if (deb_load_s) begin
        held_r  <= (snap_next_s != 16'h0000);
        multi_r <= (popcount16(snap_next_s) >= 5'd2);
      end
      if (press_s) begin
        code_r  <= first_set16(snap_next_s);
        valid_r <= 1'b1;
        ovr_r   <= ACK ? 1'b0 : (ovr_r | valid_r);
      end else if (ACK) begin
        valid_r <= 1'b0;
        ovr_r   <= 1'b0;
      end
    end
  end

  assign COL     = col_r;
  assign KEY_REG = {24'h000000, valid_r, ovr_r, held_r, multi_r, code_r};
  assign IRQ     = valid_r;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed and randomized bench for keypad_scanner_4x4 against a per-scan
// run-length model of the debounce and event rules.
module tb_keypad_scanner_4x4;

  localparam int ST = 4;
  localparam int DS = 3;

  logic        CLK = 1'b0;
  logic        RES_N;
  logic        ACK;
  logic [3:0]  col_w;
  logic [3:0]  row_s;
  logic [31:0] key_reg_w;
  logic        irq_w;
  logic [15:0] keys;

  int total;
  int fails;

  logic [15:0] m_last;
  logic [15:0] m_d;
  int          m_run;
  logic [3:0]  m_code;
  logic        m_multi, m_held, m_ovr, m_valid;

  keypad_scanner_4x4 #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .CLK     (CLK),
    .RES_N   (RES_N),
    .COL     (col_w),
    .ROW     (row_s),
    .ACK     (ACK),
    .KEY_REG (key_reg_w),
    .IRQ     (irq_w)
  );

  always #5 CLK = ~CLK;

  // Passive matrix: a closed key pulls its row low while its column is low.
  always_comb begin
    row_s = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[{2'(r), 2'(c)}] && !col_w[c]) row_s[r] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_word();
    return {24'h000000, m_valid, m_ovr, m_held, m_multi, m_code};
  endfunction

  function automatic logic [3:0] key_index(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 16'h0000; m_run = 1; m_d = 16'h0000;
    m_code = 4'd0; m_multi = 1'b0; m_held = 1'b0; m_ovr = 1'b0; m_valid = 1'b0;
  endtask

  // ackm: 0 none, 1 ACK mid-scan, 2 ACK on the end-of-scan edge.
  task automatic model_scan(input logic [15:0] snap, input int ackm);
    logic [15:0] newd;
    bit ev;
    if (snap == m_last) m_run++;
    else begin
      m_last = snap;
      m_run  = 1;
    end
    newd = (m_run >= DS) ? snap : m_d;
    ev = ($countones(m_d) == 0) && ($countones(newd) == 1);
    if (newd != m_d) begin
      m_held  = (newd != 16'h0000);
      m_multi = ($countones(newd) >= 2);
    end
    if (ev) begin
      m_code  = key_index(newd);
      m_ovr   = (ackm == 2) ? 1'b0 : (m_ovr | m_valid);
      m_valid = 1'b1;
    end else if (ackm == 2) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    m_d = newd;
  endtask

  // One full scan (16 edges) with the given key set; starts and ends #1 after an edge.
  task automatic run_scan(input logic [15:0] k, input int ackm, input bit chk_col, input string tag);
    logic [3:0] one4;
    logic [3:0] exp_col;
    one4 = 4'b0001;
    keys = k;
    for (int i = 0; i < 16; i++) begin
      if (chk_col) begin
        exp_col = ~(one4 << (i / 4));
        check("col_walk", {28'd0, col_w}, {28'd0, exp_col});
      end
      if ((ackm == 1 && i == 8) || (ackm == 2 && i == 15)) ACK = 1'b1;
      @(posedge CLK);
      #1;
      ACK = 1'b0;
      if (ackm == 1 && i == 8) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check({tag, "_ack"}, key_reg_w, exp_word());
      end
    end
    model_scan(k, ackm);
    check(tag, key_reg_w, exp_word());
    check({tag, "_irq"}, {31'd0, irq_w}, {31'd0, m_valid});
  endtask

  task automatic mid_reset(input int cycles, input string tag);
    repeat (cycles) @(posedge CLK);
    #1;
    RES_N = 1'b0;
    #1;
    check({tag, "_col"}, {28'd0, col_w}, 32'h0000000E);
    check({tag, "_reg"}, key_reg_w, 32'h00000000);
    model_reset();
    @(posedge CLK);
    #1;
    RES_N = 1'b1;
  endtask

  initial begin
    logic [15:0] rk;
    int sel, ackm;
    total = 0;
    fails = 0;
    RES_N = 1'b0;
    ACK   = 1'b0;
    keys  = 16'h0000;
    model_reset();

    repeat (3) @(posedge CLK);
    #1;
    check("rst_col", {28'd0, col_w}, 32'h0000000E);
    check("rst_reg", key_reg_w, 32'h00000000);
    check("rst_irq", {31'd0, irq_w}, 32'd0);
    RES_N = 1'b1;

    run_scan(16'h0000, 0, 1'b1, "walk");
    mid_reset(6, "midrst");

    // Single press r2c1, acknowledge, release.
    for (int s = 0; s < 3; s++) run_scan(16'h0200, 0, 1'b0, "press9");
    check("press9_lit", key_reg_w, 32'h000000A9);
    run_scan(16'h0200, 1, 1'b0, "ack9");
    check("ack9_lit", key_reg_w, 32'h00000029);
    for (int s = 0; s < 3; s++) run_scan(16'h0000, 0, 1'b0, "rel9");
    check("rel9_lit", key_reg_w, 32'h00000009);

    // Bounce on r0c3, then hold it.
    for (int s = 0; s < 8; s++) run_scan((s % 2 == 0) ? 16'h0008 : 16'h0000, 0, 1'b0, "bounce");
    check("bounce_lit", key_reg_w, 32'h00000009);
    for (int s = 0; s < 3; s++) run_scan(16'h0008, 0, 1'b0, "hold3");
    check("hold3_lit", key_reg_w, 32'h000000A3);

    // Overrun: release code 3, press code 5 without ACK.
    for (int s = 0; s < 3; s++) run_scan(16'h0000, 0, 1'b0, "rel3");
    for (int s = 0; s < 3; s++) run_scan(16'h0020, 0, 1'b0, "ovr5");
    check("ovr5_lit", key_reg_w, 32'h000000E5);
    for (int s = 0; s < 3; s++) run_scan(16'h0000, 0, 1'b0, "rel5");
    run_scan(16'h0020, 0, 1'b0, "ack5");
    run_scan(16'h0020, 0, 1'b0, "ack5");
    run_scan(16'h0020, 2, 1'b0, "ack5_coinc");
    check("ack5_lit", key_reg_w, 32'h000000A5);

    // Multi-key r0c0 + r3c3, then drop r3c3.
    run_scan(16'h0000, 1, 1'b0, "clr");
    for (int s = 0; s < 2; s++) run_scan(16'h0000, 0, 1'b0, "clr");
    for (int s = 0; s < 3; s++) run_scan(16'h8001, 0, 1'b0, "multi");
    check("multi_lit", key_reg_w, 32'h00000035);
    for (int s = 0; s < 3; s++) run_scan(16'h0001, 0, 1'b0, "two_to_one");
    check("two_to_one_lit", key_reg_w, 32'h00000025);

    // Key r1c1 held across reset is re-detected.
    for (int s = 0; s < 3; s++) run_scan(16'h0000, 0, 1'b0, "rel0");
    for (int s = 0; s < 3; s++) run_scan(16'h0020, 0, 1'b0, "pre_rst");
    mid_reset(7, "keyrst");
    for (int s = 0; s < 3; s++) run_scan(16'h0020, 0, 1'b0, "post_rst");
    check("post_rst_lit", key_reg_w, 32'h000000A5);

    // Randomized key sets and ACK placement.
    rk = 16'h0000;
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 4 && sel <= 5) rk = 16'h0000;
      else if (sel >= 6 && sel <= 8) rk = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 9) rk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      sel  = $urandom_range(0, 5);
      ackm = (sel < 4) ? 0 : sel - 3;
      run_scan(rk, ackm, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
